dmem_run_ctrl: RTL
==================

Name: dmem_run_ctrl

Overview:
Run sequencer and data-memory owner arbiter for the tiny core executing programs such as float-to-int.
- A host (bench or loader) writes operands into data memory, then requests a run.
- The block pulses the core's start and hands memory ownership to the core until done.
- It then returns ownership to the host, reports cycle count and status, and traps hung runs with a watchdog.

Parameters:
AW, 8, data-memory address width
DW, 8, data-memory word width
START_CYCLES, 2, cycles core_start is held high (minimum 1)
TIMEOUT, 4096, watchdog limit in core cycles (RUN state)
CW, 16, cycle counter width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
run_req  in  1  host requests a program run (level; sampled in IDLE only)
run_busy  out  1  high from START through RUN
run_done  out  1  one-cycle pulse at run completion (normal or timeout)
run_timeout  out  1  sticky; set on watchdog expiry, cleared at next accepted run_req
run_cycles  out  CW  cycles spent in RUN for last run, saturating
host_we  in  1  host write enable
host_addr  in  AW  host address
host_wdata  in  DW  host write data
host_rdata  out  DW  mem_rdata passthrough, valid only when host owns memory, else 0
host_err  out  1  one-cycle pulse: host_we asserted while core owns memory (write dropped)
core_start  out  1  start to core
core_done  in  1  done from core (level)
core_we  in  1  core write enable
core_addr  in  AW  core address
core_wdata  in  DW  core write data
core_rdata  out  DW  mem_rdata passthrough, 0 when host owns memory
mem_we  out  1  to data memory
mem_addr  out  AW  to data memory
mem_wdata  out  DW  to data memory
mem_rdata  in  DW  from data memory (combinational read)

Behaviour:
- Reset (reset==0, async): state IDLE, core_start=0, run_busy=0, run_done=0, run_timeout=0, run_cycles=0, host_err=0, host owns memory.
- States:
  - IDLE: host owns memory. run_req==1 -> START; clear run_timeout and run_cycles at the transition.
  - START: core owns memory; core_start=1 for exactly START_CYCLES cycles -> RUN. core_done during START is ignored; this covers a stale done from the previous run.
  - RUN: core_start=0; run_cycles increments each cycle and saturates at all-ones. core_done==1 -> FIN. Counter reaching TIMEOUT-1 without done -> FIN with run_timeout set.
  - FIN: single cycle; run_done=1, host owns memory again -> IDLE.
- Ownership mux is combinational on registered state:
  - Host owns in IDLE and FIN; core owns in START and RUN.
  - The non-owner's we is gated to 0 and its rdata is forced to 0.
- Host write while core owns memory: mem_we stays 0; host_err pulses the next cycle for each such cycle.
- core_done and core_we in the same RUN cycle: the write completes, since mem sees it that cycle. Transition to FIN follows.
- run_req held high through FIN: IDLE re-accepts it on the next cycle. A new run starts every START_CYCLES+run+2 cycles.
- run_req outside IDLE: ignored, not queued.
- run_busy is a registered decode: (state==START or state==RUN).
- Reset asserted mid-run: immediate return to IDLE, core_start dropped in the same instant, host owns memory.

Optional Feature:
DMEM_RUN_CTRL_WATCHDOG_EN
- Defined: TIMEOUT watchdog active as described.
- Undefined: RUN waits indefinitely for core_done, run_timeout is tied 0, and the TIMEOUT parameter is unused.

Decomposition:
- Shared package dmem_run_pkg: state enum typedef (IDLE, START, RUN, FIN), default width constants AW/DW/CW.
- One natural sub-module: dmem_owner_mux. Purely combinational port steering keyed on a host_owns bit, including the we gating and rdata zeroing.
- FSM, counters and host_err live in the top.

Test Plan:
1. Host writes 8'h00 to addr 4 and 8'h3C to addr 5, run_req=1 for one cycle; core model asserts done after 37 RUN cycles.
   -> core_start high exactly 2 cycles, run_done single pulse, run_cycles==37, run_timeout==0; host then reads addr 6/7 via host_rdata.
2. host_we=1 to addr 6 during RUN.
   -> mem_we follows core_we only, host_err pulses once per offending cycle, memory contents at addr 6 unchanged by host.
3. Watchdog build, TIMEOUT=64, core never asserts done.
   -> run_done pulse after 64 RUN cycles, run_timeout==1 sticky until next run_req; without the macro, run_busy stays 1 for 10000 cycles.
4. Stale core_done=1 held from the previous run through START.
   -> ignored in START; RUN exits on its first cycle, run_cycles==1.
5. reset driven low mid-RUN at cycle 10.
   -> core_start/run_busy 0 immediately, host owns memory, run_cycles==0, run_done never pulses.
6. run_req held high continuously with done at RUN cycle 5.
   -> back-to-back runs; run_done pulses every 9 cycles (2 START + 5 RUN + FIN + IDLE), run_timeout stays 0.

Source files
------------

// File: rtl/dmem_run_pkg.sv
// Shared types and defaults for the data-memory run sequencer.
// Contents:
//   DefAw/DefDw/DefCw - default address, data and cycle-counter widths
//   run_state_e       - sequencer states (idle, start pulse, run, finish)
//   state_host_owns   - decode of which side owns data memory in a state
package dmem_run_pkg;

  localparam int unsigned DefAw = 8;
  localparam int unsigned DefDw = 8;
  localparam int unsigned DefCw = 16;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StRun,
    StFin
  } run_state_e;

  // Host holds the memory whenever the core is not actively running.
  function automatic logic state_host_owns(run_state_e s);
    return (s == StIdle) || (s == StFin);
  endfunction

endpackage

// File: rtl/dmem_owner_mux.sv
// Combinational steering of the data-memory port between host and core.
// Ports:
//   host_owns_i          - 1: host drives memory, 0: core drives memory
//   host_we/addr/wdata_i - host request; host_rdata_o is zero unless host owns
//   core_we/addr/wdata_i - core request; core_rdata_o is zero unless core owns
//   mem_we/addr/wdata_o  - to data memory; mem_rdata_i from data memory
module dmem_owner_mux #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          host_owns_i,
  input  logic          host_we_i,
  input  logic [AW-1:0] host_addr_i,
  input  logic [DW-1:0] host_wdata_i,
  output logic [DW-1:0] host_rdata_o,
  input  logic          core_we_i,
  input  logic [AW-1:0] core_addr_i,
  input  logic [DW-1:0] core_wdata_i,
  output logic [DW-1:0] core_rdata_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  always_comb begin
    if (host_owns_i) begin
      mem_we_o     = host_we_i;
      mem_addr_o   = host_addr_i;
      mem_wdata_o  = host_wdata_i;
      host_rdata_o = mem_rdata_i;
      core_rdata_o = '0;
    end else begin
      mem_we_o     = core_we_i;
      mem_addr_o   = core_addr_i;
      mem_wdata_o  = core_wdata_i;
      host_rdata_o = '0;
      core_rdata_o = mem_rdata_i;
    end
  end

endmodule

// File: rtl/dmem_run_ctrl.sv
// Run sequencer and data-memory owner arbiter for a tiny core.
// The host loads operands, raises run_req_i; the block pulses core_start_o for
// START_CYCLES cycles, lets the core own memory until core_done_i, then hands
// memory back, pulses run_done_o and reports run_cycles_o / run_timeout_o.
// Build option: define DMEM_RUN_CTRL_WATCHDOG_EN to enable the TIMEOUT watchdog;
// otherwise RUN waits indefinitely and run_timeout_o stays 0.
// Ports:
//   clk_i, rst_ni            - clock, asynchronous active-low reset
//   run_req_i                - run request (level, sampled in idle only)
//   run_busy_o, run_done_o   - busy from start through run, completion pulse
//   run_timeout_o            - sticky watchdog flag, cleared on accepted request
//   run_cycles_o             - saturating count of run-state cycles of last run
//   host_we/addr/wdata_i, host_rdata_o, host_err_o - host memory port
//   core_start_o, core_done_i, core_we/addr/wdata_i, core_rdata_o - core side
//   mem_we/addr/wdata_o, mem_rdata_i - data memory
module dmem_run_ctrl
  import dmem_run_pkg::*;
#(
  parameter int unsigned AW           = DefAw,
  parameter int unsigned DW           = DefDw,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 4096,
  parameter int unsigned CW           = DefCw
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          run_req_i,
  output logic          run_busy_o,
  output logic          run_done_o,
  output logic          run_timeout_o,
  output logic [CW-1:0] run_cycles_o,
  input  logic          host_we_i,
  input  logic [AW-1:0] host_addr_i,
  input  logic [DW-1:0] host_wdata_i,
  output logic [DW-1:0] host_rdata_o,
  output logic          host_err_o,
  output logic          core_start_o,
  input  logic          core_done_i,
  input  logic          core_we_i,
  input  logic [AW-1:0] core_addr_i,
  input  logic [DW-1:0] core_wdata_i,
  output logic [DW-1:0] core_rdata_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

`ifdef DMEM_RUN_CTRL_WATCHDOG_EN
  localparam bit WdEn = 1'b1;
`else
  localparam bit WdEn = 1'b0;
`endif

  localparam int unsigned ScW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [ScW-1:0] ScLast = ScW'(START_CYCLES - 1);
  localparam logic [CW-1:0]  WdLast = CW'(TIMEOUT - 1);

  run_state_e     state_q, state_d;
  logic [ScW-1:0] start_cnt_q, start_cnt_d;
  logic [CW-1:0]  cycles_q, cycles_d;
  logic           timeout_q, timeout_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic           host_owns;
  logic           accept;
  logic           wd_hit;

  assign host_owns = state_host_owns(state_q);
  assign accept    = (state_q == StIdle) && run_req_i;
  // Watchdog fires on the TIMEOUT-th run cycle only if done is not also present.
  assign wd_hit    = WdEn && (state_q == StRun) && !core_done_i && (cycles_q == WdLast);

  // State register and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      start_cnt_q <= '0;
      cycles_q    <= '0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_cnt_q <= start_cnt_d;
      cycles_q    <= cycles_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic. core_done_i is only looked at in run, so a stale done
  // left over from the previous run cannot cut the start pulse short.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (run_req_i) state_d = StStart;
      StStart: if (start_cnt_q == ScLast) state_d = StRun;
      StRun:   if (core_done_i || wd_hit) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Counters, sticky flags and registered status decodes.
  always_comb begin
    start_cnt_d = (state_q == StStart) ? start_cnt_q + 1'b1 : '0;
    cycles_d    = cycles_q;
    timeout_d   = timeout_q;
    if (accept) begin
      cycles_d  = '0;
      timeout_d = 1'b0;
    end
    if (state_q == StRun) begin
      if (cycles_q != '1) cycles_d = cycles_q + 1'b1;
      if (wd_hit) timeout_d = 1'b1;
    end
    busy_d = (state_d == StStart) || (state_d == StRun);
    err_d  = host_we_i && !host_owns;
  end

  // Outputs.
  always_comb begin
    core_start_o  = (state_q == StStart);
    run_done_o    = (state_q == StFin);
    run_busy_o    = busy_q;
    run_timeout_o = timeout_q;
    run_cycles_o  = cycles_q;
    host_err_o    = err_q;
  end

  dmem_owner_mux #(
    .AW (AW),
    .DW (DW)
  ) u_owner_mux (
    .host_owns_i  (host_owns),
    .host_we_i    (host_we_i),
    .host_addr_i  (host_addr_i),
    .host_wdata_i (host_wdata_i),
    .host_rdata_o (host_rdata_o),
    .core_we_i    (core_we_i),
    .core_addr_i  (core_addr_i),
    .core_wdata_i (core_wdata_i),
    .core_rdata_o (core_rdata_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i)
  );

endmodule
